chacha_host_driver: RTL and testbench

Host-side driver for the small ChaCha core's byte-wide pin interface. It sits at the far end of the chip's pins: in the FPGA test harness or on the TT demo board. It accepts 48 key/counter/nonce bytes on a valid/ready stream and writes them into the core with a write strobe, then issues start and waits for the core's busy flag to fall. It then reads the 64 keystream bytes back with a read strobe and presents them on an output valid/ready stream.

---
 rtl/chacha_host_driver.sv | 133 +++++++++++++
 tb/tb_chacha_host_driver.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_host_driver.sv
// chacha_host_driver: streams a 48-byte load into the ChaCha pin interface, runs it, reads 64 bytes back.
// Optional busy watchdog with sticky error: define CHACHA_DRV_WATCHDOG_EN.
module chacha_host_driver #(
  parameter int LOAD_BYTES = 48,
  parameter int READ_BYTES = 64
`ifdef CHACHA_DRV_WATCHDOG_EN
  ,
  parameter int TIMEOUT = 1023
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] dev_data_o,
  output logic       dev_wr_o,
  output logic       dev_rd_o,
  output logic       dev_start_o,
  input  logic [7:0] dev_data_i,
  input  logic       dev_busy_i,
  output logic       error
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
    S_START,
    S_WAIT,
    S_RDREQ,
    S_RDCAP,
    S_EMIT
`ifdef CHACHA_DRV_WATCHDOG_EN
    ,
    S_ERR
`endif
  } state_t;

  state_t     state;
  state_t     next;
  logic [5:0] bcnt;
  logic [6:0] rcnt;
  logic       wait_seen;
  logic       in_hs;
  logic       out_hs;

`ifdef CHACHA_DRV_WATCHDOG_EN
  logic [9:0] wcnt;
`endif

  assign in_ready  = !rst && (state == S_IDLE || state == S_LOAD);
  assign out_valid = (state == S_EMIT);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE, S_LOAD: begin
        if (in_hs) next = S_STROBE;
      end
      S_STROBE: begin
        if (bcnt + 6'd1 == 6'(LOAD_BYTES)) next = S_START;
        else next = S_LOAD;
      end
      S_START: next = S_WAIT;
      S_WAIT: begin
        // busy is registered in the chip, so the first WAIT cycle is stale
        if (wait_seen && !dev_busy_i) next = S_RDREQ;
`ifdef CHACHA_DRV_WATCHDOG_EN
        else if (wcnt == 10'(TIMEOUT - 1)) next = S_ERR;
`endif
      end
      S_RDREQ: next = S_RDCAP;
      S_RDCAP: next = S_EMIT;
      S_EMIT: begin
        if (out_hs) begin
          if (rcnt + 7'd1 == 7'(READ_BYTES)) next = S_IDLE;
          else next = S_RDREQ;
        end
      end
`ifdef CHACHA_DRV_WATCHDOG_EN
      S_ERR: next = S_ERR;
`endif
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bcnt        <= '0;
      rcnt        <= '0;
      wait_seen   <= 1'b0;
      dev_data_o  <= '0;
      out_data    <= '0;
      dev_wr_o    <= 1'b0;
      dev_rd_o    <= 1'b0;
      dev_start_o <= 1'b0;
    end else begin
      state       <= next;
      dev_wr_o    <= (next == S_STROBE);
      dev_rd_o    <= (next == S_RDREQ);
      dev_start_o <= (next == S_START);
      wait_seen   <= (state == S_WAIT);
      if (in_hs) dev_data_o <= in_data;
      if (state == S_IDLE) bcnt <= '0;
      else if (state == S_STROBE) bcnt <= bcnt + 6'd1;
      if (state == S_WAIT) rcnt <= '0;
      else if (out_hs) rcnt <= rcnt + 7'd1;
      if (state == S_RDCAP) out_data <= dev_data_i;
    end
  end

`ifdef CHACHA_DRV_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt  <= '0;
      error <= 1'b0;
    end else begin
      wcnt  <= (state == S_WAIT) ? wcnt + 10'd1 : '0;
      error <= error || (next == S_ERR);
    end
  end
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_chacha_host_driver.sv
// tb_chacha_host_driver: directed bench with a small pin-level chip model.
// Build with CHACHA_DRV_WATCHDOG_EN defined to exercise the watchdog path.
module tb_chacha_host_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] dev_data_o;
  logic       dev_wr_o;
  logic       dev_rd_o;
  logic       dev_start_o;
  logic [7:0] dev_data_i = '0;
  logic       dev_busy_i;
  logic       error;

  int passed = 0;
  int total = 0;
  int timeouts = 0;

  always #5 clk = ~clk;

  chacha_host_driver dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .dev_data_o(dev_data_o), .dev_wr_o(dev_wr_o), .dev_rd_o(dev_rd_o),
    .dev_start_o(dev_start_o), .dev_data_i(dev_data_i),
    .dev_busy_i(dev_busy_i), .error(error)
  );

  // chip model: busy for busy_len cycles after start, read data one cycle after strobe
  int         bcnt_c = 0;
  int         busy_len = 20;
  logic       stuck = 1'b0;
  logic [6:0] ridx = '0;

  assign dev_busy_i = stuck || (bcnt_c != 0);

  always @(posedge clk) begin
    if (dev_start_o) begin
      bcnt_c <= busy_len;
      ridx   <= '0;
    end else if (bcnt_c != 0) begin
      bcnt_c <= bcnt_c - 1;
    end
    if (dev_rd_o) begin
      dev_data_i <= 8'hA0 + 8'(ridx);
      ridx       <= ridx + 7'd1;
    end
  end

  // monitor
  int         cyc = 0;
  logic       mon_clr = 1'b0;
  logic [7:0] wr_log [64];
  logic [7:0] out_log [128];
  int         wr_cnt = 0, wr_last = 0, wr_gap_err = 0;
  int         start_cnt = 0, start_cyc = 0, rd_cnt = 0;
  int         out_cnt = 0, out_last = 0, out_gap_err = 0;
  int         stab_err = 0, overlap_err = 0, rd_in_emit = 0;
  int         in_first = -1, err_cyc = -1;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt <= 0; wr_gap_err <= 0; start_cnt <= 0; rd_cnt <= 0;
      out_cnt <= 0; out_gap_err <= 0; stab_err <= 0; overlap_err <= 0;
      rd_in_emit <= 0; in_first <= -1; err_cyc <= -1; stall_prev <= 1'b0;
    end else begin
      if (dev_wr_o) begin
        if (wr_cnt < 64) wr_log[wr_cnt] <= dev_data_o;
        if (wr_cnt != 0 && cyc - wr_last != 2) wr_gap_err <= wr_gap_err + 1;
        wr_cnt  <= wr_cnt + 1;
        wr_last <= cyc;
      end
      if (dev_start_o) begin
        start_cnt <= start_cnt + 1;
        start_cyc <= cyc;
      end
      if (dev_rd_o) rd_cnt <= rd_cnt + 1;
      if (dev_rd_o && (out_valid || stall_prev)) rd_in_emit <= rd_in_emit + 1;
      if (int'(dev_wr_o) + int'(dev_rd_o) + int'(dev_start_o) > 1)
        overlap_err <= overlap_err + 1;
      if (stall_prev && (!out_valid || out_data !== stall_data))
        stab_err <= stab_err + 1;
      stall_prev <= out_valid && !out_ready;
      stall_data <= out_data;
      if (in_valid && in_ready && in_first < 0) in_first <= cyc;
      if (out_valid && out_ready) begin
        if (out_cnt < 128) out_log[out_cnt] <= out_data;
        if (out_cnt != 0 && cyc - out_last != 3) out_gap_err <= out_gap_err + 1;
        out_cnt  <= out_cnt + 1;
        out_last <= cyc;
      end
      if (error && err_cyc < 0) err_cyc <= cyc;
    end
  end

  task automatic clear_mon();
    @(negedge clk);
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic load_bytes(input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      in_data  = 8'(i);
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) timeouts++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input bit rnd, input int n);
    int t;
    t = 0;
    while (out_cnt < n && t < 3000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      t++;
    end
    if (t >= 3000) timeouts++;
    out_ready = 1'b0;
  endtask

  task automatic wait_start();
    int t;
    t = 0;
    while (start_cnt == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeouts++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got %h want 00", out_data); else passed++;
    total++; if (dev_data_o !== 8'h00) $display("FAIL rst_dev_data: got %h want 00", dev_data_o); else passed++;
    total++; if ({dev_wr_o, dev_rd_o, dev_start_o} !== 3'b000)
      $display("FAIL rst_strobes: got %b want 000", {dev_wr_o, dev_rd_o, dev_start_o}); else passed++;
    total++; if (error !== 1'b0) $display("FAIL rst_error: got %b want 0", error); else passed++;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic check_block(input string tag, input bit timing);
    int bad_w, bad_o;
    bad_w = 0;
    bad_o = 0;
    for (int i = 0; i < 48; i++) if (wr_log[i] !== 8'(i)) bad_w++;
    for (int i = 0; i < 64; i++) if (out_log[i] !== 8'hA0 + 8'(i)) bad_o++;
    total++; if (wr_cnt !== 48) $display("FAIL %s wr_count: got %0d want 48", tag, wr_cnt); else passed++;
    total++; if (bad_w !== 0) $display("FAIL %s wr_data: %0d bytes wrong, want 0", tag, bad_w); else passed++;
    total++; if (start_cnt !== 1) $display("FAIL %s start_count: got %0d want 1", tag, start_cnt); else passed++;
    total++; if (rd_cnt !== 64) $display("FAIL %s rd_count: got %0d want 64", tag, rd_cnt); else passed++;
    total++; if (out_cnt !== 64) $display("FAIL %s out_count: got %0d want 64", tag, out_cnt); else passed++;
    total++; if (bad_o !== 0) $display("FAIL %s out_data: %0d bytes wrong, want 0", tag, bad_o); else passed++;
    total++; if (wr_gap_err !== 0) $display("FAIL %s wr_spacing: %0d bad gaps, want 0", tag, wr_gap_err); else passed++;
    total++; if (overlap_err !== 0) $display("FAIL %s strobe_overlap: got %0d want 0", tag, overlap_err); else passed++;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s end_idle: valid=%b ready=%b want 0/1", tag, out_valid, in_ready); else passed++;
    total++; if (timeouts !== 0) $display("FAIL %s timeout: got %0d want 0", tag, timeouts); else passed++;
    if (timing) begin
      total++; if (out_last - in_first !== 309)
        $display("FAIL %s latency: got %0d want 309", tag, out_last - in_first); else passed++;
      total++; if (out_gap_err !== 0) $display("FAIL %s out_spacing: %0d bad gaps, want 0", tag, out_gap_err); else passed++;
    end
  endtask

  task automatic test_load_read();
    clear_mon();
    load_bytes(48);
    drain(1'b0, 64);
    check_block("block", 1'b1);
  endtask

  task automatic test_stall();
    clear_mon();
    load_bytes(48);
    drain(1'b1, 64);
    check_block("stall", 1'b0);
    total++; if (stab_err !== 0) $display("FAIL stall_stable: %0d changes, want 0", stab_err); else passed++;
    total++; if (rd_in_emit !== 0) $display("FAIL stall_rd: %0d reads in EMIT, want 0", rd_in_emit); else passed++;
  endtask

  task automatic test_reset_mid();
    clear_mon();
    load_bytes(20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if ({dev_wr_o, dev_rd_o, dev_start_o} !== 3'b000 || in_ready !== 1'b1)
      $display("FAIL rst_load: strobes=%b ready=%b want 000/1", {dev_wr_o, dev_rd_o, dev_start_o}, in_ready); else passed++;
    clear_mon();
    load_bytes(48);
    drain(1'b0, 64);
    check_block("after_rst_load", 1'b0);

    clear_mon();
    load_bytes(48);
    wait_start();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if ({dev_wr_o, dev_rd_o, dev_start_o} !== 3'b000 || in_ready !== 1'b1)
      $display("FAIL rst_wait: strobes=%b ready=%b want 000/1", {dev_wr_o, dev_rd_o, dev_start_o}, in_ready); else passed++;
    total++; if (rd_cnt !== 0) $display("FAIL rst_wait_rd: got %0d want 0", rd_cnt); else passed++;
    clear_mon();
    load_bytes(48);
    drain(1'b0, 64);
    check_block("after_rst_wait", 1'b0);
  endtask

  task automatic test_watchdog();
    clear_mon();
    stuck = 1'b1;
    load_bytes(48);
    wait_start();
`ifdef CHACHA_DRV_WATCHDOG_EN
    begin
      int t;
      t = 0;
      while (!error && t < 1200) begin
        @(negedge clk);
        t++;
      end
    end
    total++; if (err_cyc - start_cyc !== 1024)
      $display("FAIL wd_rise: error seen %0d edges after start, want 1024", err_cyc - start_cyc); else passed++;
    repeat (50) @(negedge clk);
    total++; if (error !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL wd_sticky: err=%b ready=%b valid=%b want 1/0/0", error, in_ready, out_valid); else passed++;
    stuck = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (error !== 1'b1) $display("FAIL wd_hold: got %b want 1", error); else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (error !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL wd_clear: err=%b ready=%b want 0/1", error, in_ready); else passed++;
`else
    repeat (1100) @(negedge clk);
    total++; if (error !== 1'b0) $display("FAIL nowd_error: got %b want 0", error); else passed++;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || rd_cnt !== 0)
      $display("FAIL nowd_wait: ready=%b valid=%b rd=%0d want 0/0/0", in_ready, out_valid, rd_cnt); else passed++;
    stuck = 1'b0;
    drain(1'b0, 64);
    check_block("nowd_release", 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_load_read();
    test_stall();
    test_reset_mid();
    test_watchdog();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
